// File: rtl/pc_update.sv
// pc_update: program-counter register, next-PC selection and processor
// status FSM for the single-cycle Y86-64 core.
//
// Ports
//   clk_i, rst_n_i        core clock (rising edge), async active-low reset
//   stall_i               hold PC, status and counters this cycle
//   icode_i, cnd_i        instruction code and branch condition
//   valC_i, valP_i        constant word and fall-through address
//   valM_i                memory read data (return address for RET)
//   instr_valid_i         fetch reports a legal icode
//   imem_error_i          fetch reports PC outside instruction memory
//   dmem_error_i          memory stage reports a data address fault
//   PC_o                  current PC, fed to fetch
//   stat_o                0=AOK 1=HLT 2=ADR 3=INS
//   halted_o              1 whenever stat_o != AOK
//   retired_o, taken_o    (PC_PERF_CNT_EN only) saturating retire / control
//                         transfer counters
//
// Optional feature macro: PC_PERF_CNT_EN adds the two performance counters.
//
// FSM states
//   state   | meaning
//   ST_RUN  | AOK, PC advances every unstalled cycle
//   ST_HALT | halt instruction retired, core frozen until reset
//   ST_ADR  | instruction or data address fault, frozen until reset
//   ST_INS  | illegal instruction, frozen until reset
module pc_update #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valP_i,
  input  logic [63:0] valM_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        dmem_error_i,
  output logic [63:0] PC_o,
  output logic [1:0]  stat_o,
  output logic        halted_o
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0] retired_o,
  output logic [31:0] taken_o
`endif
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_ADR  = 2'd2;
  localparam logic [1:0] ST_INS  = 2'd3;

  // The depth only matters to fetch's range check; reject a nonsensical value.
  if (IMEM_DEPTH < 1) begin : g_bad_depth
    $error("pc_update: IMEM_DEPTH must be at least 1");
  end

  logic [63:0] r_pc;
  logic [1:0]  r_state;
  logic        r_halted;

  logic        w_take_c;
  logic        w_take_m;
  logic        w_ctrl;
  logic [63:0] w_next_pc;
  logic [63:0] w_pc_nxt;
  logic [1:0]  w_state_nxt;
  logic        w_retire;

  always_comb begin
    w_take_c  = (icode_i == ICALL) || ((icode_i == IJXX) && cnd_i);
    w_take_m  = (icode_i == IRET);
    w_ctrl    = w_take_c || w_take_m;
    w_next_pc = w_take_c ? valC_i : (w_take_m ? valM_i : valP_i);
  end

  // Fault and halt transitions keep PC pointing at the offending instruction.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_retire    = 1'b0;
    if ((r_state == ST_RUN) && !stall_i) begin
      if (imem_error_i)            w_state_nxt = ST_ADR;
      else if (!instr_valid_i)     w_state_nxt = ST_INS;
      else if (dmem_error_i)       w_state_nxt = ST_ADR;
      else if (icode_i == IHALT)   w_state_nxt = ST_HALT;
      else begin
        w_pc_nxt = w_next_pc;
        w_retire = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc     <= RESET_PC;
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt != ST_RUN);
    end
  end

  assign PC_o     = r_pc;
  assign stat_o   = r_state;
  assign halted_o = r_halted;

`ifdef PC_PERF_CNT_EN
  logic [31:0] r_retired;
  logic [31:0] r_taken;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_retired <= 32'd0;
      r_taken   <= 32'd0;
    end else if (w_retire) begin
      if (r_retired != 32'hFFFF_FFFF) r_retired <= r_retired + 32'd1;
      if (w_ctrl && (r_taken != 32'hFFFF_FFFF)) r_taken <= r_taken + 32'd1;
    end
  end

  assign retired_o = r_retired;
  assign taken_o   = r_taken;
`else
  logic w_unused;
  assign w_unused = w_ctrl;
`endif

endmodule
